// File: rtl/anim_sequencer.sv
// +----------------------------------------------------------------------+
// | anim_sequencer: plays ROM frames onto an 8x8 row-scanned LED matrix.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module anim_sequencer #(
  parameter int ROW_TICKS   = 1000,
  parameter int FRAME_SCANS = 50,
  parameter int NUM_FRAMES  = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        loop_en,
  output logic [3:0]  rom_addr,
  input  logic [63:0] rom_data,
  output logic [7:0]  row_sel,
  output logic [7:0]  col_data,
  output logic        busy,
  output logic        done
);

  localparam int c_TICK_W = (ROW_TICKS   > 1) ? $clog2(ROW_TICKS)   : 1;
  localparam int c_SCAN_W = (FRAME_SCANS > 1) ? $clog2(FRAME_SCANS) : 1;

  localparam logic [c_TICK_W-1:0] c_TICK_LAST  = c_TICK_W'(ROW_TICKS - 1);
  localparam logic [c_SCAN_W-1:0] c_SCAN_LAST  = c_SCAN_W'(FRAME_SCANS - 1);
  localparam logic [3:0]          c_FRAME_LAST = 4'(NUM_FRAMES - 1);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_LOAD = 2'd1;
  localparam logic [1:0] c_ST_SCAN = 2'd2;

  logic [1:0]          r_state;
  logic [3:0]          r_frame;
  logic [2:0]          r_row;
  logic [c_TICK_W-1:0] r_tick;
  logic [c_SCAN_W-1:0] r_scan;
  logic [63:0]         r_buf;
  logic                r_done;

  logic w_tick_last;
  logic w_row_last;
  logic w_scan_last;
  logic w_frame_last;

  assign w_tick_last  = (r_tick  == c_TICK_LAST);
  assign w_row_last   = (r_row   == 3'd7);
  assign w_scan_last  = (r_scan  == c_SCAN_LAST);
  assign w_frame_last = (r_frame == c_FRAME_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_ST_IDLE;
      r_frame <= 4'd0;
      r_row   <= 3'd0;
      r_tick  <= '0;
      r_scan  <= '0;
      r_buf   <= 64'd0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_ST_IDLE: begin
          if (start && !stop) begin
            r_state <= c_ST_LOAD;
            r_frame <= 4'd0;
          end
        end

        c_ST_LOAD: begin
          r_buf  <= rom_data;
          r_row  <= 3'd0;
          r_tick <= '0;
          r_scan <= '0;
          if (stop) begin
            r_state <= c_ST_IDLE;
            r_frame <= 4'd0;
          end else begin
            r_state <= c_ST_SCAN;
          end
        end

        c_ST_SCAN: begin
          if (stop) begin
            r_state <= c_ST_IDLE;
            r_frame <= 4'd0;
          end else if (w_tick_last) begin
            r_tick <= '0;
            r_row  <= r_row + 3'd1;
            if (w_row_last) begin
              if (!w_scan_last) begin
                r_scan <= r_scan + c_SCAN_W'(1);
              end else begin
                r_scan <= '0;
                // End of frame: advance, wrap on loop, or finish.
                if (!w_frame_last) begin
                  r_frame <= r_frame + 4'd1;
                  r_state <= c_ST_LOAD;
                end else if (loop_en) begin
                  r_frame <= 4'd0;
                  r_state <= c_ST_LOAD;
                end else begin
                  r_frame <= 4'd0;
                  r_state <= c_ST_IDLE;
                  r_done  <= 1'b1;
                end
              end
            end
          end else begin
            r_tick <= r_tick + c_TICK_W'(1);
          end
        end

        default: begin
          r_state <= c_ST_IDLE;
          r_frame <= 4'd0;
        end
      endcase
    end
  end

  // Row r shows buffer byte [63-8r:56-8r]; ~r_row equals 7-r for a 3-bit row.
  always_comb begin
    row_sel  = 8'h00;
    col_data = 8'h00;
    if (r_state == c_ST_SCAN) begin
      row_sel  = 8'h01 << r_row;
      col_data = r_buf[{~r_row, 3'b000} +: 8];
    end
  end

  assign rom_addr = r_frame;
  assign busy     = (r_state != c_ST_IDLE);
  assign done     = r_done;

endmodule

`default_nettype wire
